// File: rtl/rtc_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : rtc_pkg
//  Purpose  : Shared constants, FSM state type and load-range helper for the
//             real-time-clock counter.
//  Contents : SEC_MAX, MIN_MAX, HOUR_MAX, state_t (RUN, LOAD), fields_ok()
//  Revision : 1.0 - initial release
// ============================================================================
package rtc_pkg;

  localparam logic [5:0] SEC_MAX  = 6'd59;
  localparam logic [5:0] MIN_MAX  = 6'd59;
  localparam logic [4:0] HOUR_MAX = 5'd23;

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    LOAD = 1'b1
  } state_t;

  // True when a 24-hour load value is a legal time of day.
  function automatic logic fields_ok(input logic [4:0] h,
                                     input logic [5:0] m,
                                     input logic [5:0] s);
    return (h <= HOUR_MAX) && (m <= MIN_MAX) && (s <= SEC_MAX);
  endfunction

endpackage
`default_nettype wire

// File: rtl/hour_fmt.sv
`default_nettype none
// ============================================================================
//  Module   : hour_fmt
//  Purpose  : Combinational 12/24-hour display decode of the internal
//             24-hour count.
//  Ports    : hour24 [4:0] in  - internal hour, 0..23
//             mode12       in  - 1 = 12-hour display, 0 = 24-hour display
//             hour   [4:0] out - displayed hour
//             nAM_PM       out - 1 for afternoon (hour24 > 11), both formats
//  Revision : 1.0 - initial release
// ============================================================================
module hour_fmt (
  input  logic [4:0] hour24,
  input  logic       mode12,
  output logic [4:0] hour,
  output logic       nAM_PM
);

  logic [4:0] w_hour12;

  // Midnight shows as 12, afternoon hours fold down by 12.
  always_comb begin
    w_hour12 = hour24;
    if (hour24 == 5'd0) begin
      w_hour12 = 5'd12;
    end else if (hour24 > 5'd12) begin
      w_hour12 = hour24 - 5'd12;
    end
  end

  assign hour   = mode12 ? w_hour12 : hour24;
  assign nAM_PM = (hour24 > 5'd11);

endmodule
`default_nettype wire

// File: rtl/rtc_counter.sv
`default_nettype none
// ============================================================================
//  Module   : rtc_counter
//  Purpose  : Real-time clock: prescaler divides clk down to one tick per
//             second, driving sec/min/hour24 counters, with a one-shot
//             time-load handshake and an optional alarm comparator.
//  Params   : CLK_HZ - clk cycles per second (>= 2)
//  Ports    : clk, rst (async, active high)
//             en            - counting enable (low pauses prescaler + time)
//             mode12        - display format, 1 = 12-hour
//             set_valid/set_ready, set_hour/min/sec - 24-hour time load
//             set_err       - one-cycle pulse on rejected load
//             hour/min/sec, nAM_PM - current time
//             tick, day_wrap - one-cycle second / midnight pulses
//             alarm_hour/min/arm, alarm - alarm compare (optional)
//  Macros   : RTC_ALARM_EN - builds the alarm comparator; when undefined the
//             alarm output is tied low and the alarm inputs are ignored.
//  Revision : 1.0 - initial release
// ============================================================================
module rtc_counter
  import rtc_pkg::*;
#(
  parameter int CLK_HZ = 100_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       mode12,
  input  logic       set_valid,
  output logic       set_ready,
  input  logic [4:0] set_hour,
  input  logic [5:0] set_min,
  input  logic [5:0] set_sec,
  output logic       set_err,
  output logic [4:0] hour,
  output logic [5:0] min,
  output logic [5:0] sec,
  output logic       nAM_PM,
  output logic       tick,
  output logic       day_wrap,
  input  logic [4:0] alarm_hour,
  input  logic [5:0] alarm_min,
  input  logic       alarm_arm,
  output logic       alarm
);

  localparam int            PW       = $clog2(CLK_HZ);
  localparam logic [PW-1:0] PRE_LAST = PW'(CLK_HZ - 1);

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_rdy;
  logic [PW-1:0] r_presc;
  logic [5:0]    r_sec;
  logic [5:0]    r_min;
  logic [4:0]    r_hour24;
  logic          r_tick;
  logic          r_day_wrap;
  logic          r_set_err;
  logic [4:0]    r_ld_hour;
  logic [5:0]    r_ld_min;
  logic [5:0]    r_ld_sec;

  logic          w_accept;
  logic          w_tick_due;
  logic          w_sec_wrap;
  logic          w_min_wrap;
  logic          w_hour_wrap;
  logic [5:0]    w_sec_nxt;
  logic [5:0]    w_min_nxt;
  logic [4:0]    w_hour_nxt;

  // --------------------------------------------------------------------------
  // Load handshake FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RUN:     if (w_accept) w_state_nxt = LOAD;
      LOAD:    w_state_nxt = RUN;
      default: w_state_nxt = RUN;
    endcase
  end

  // r_rdy holds set_ready low through reset and releases it on the first
  // edge afterwards, even though the FSM itself already sits in RUN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdy <= 1'b0;
    end else begin
      r_rdy <= 1'b1;
    end
  end

  assign set_ready = r_rdy && (r_state == RUN);
  assign w_accept  = set_valid && set_ready;

  // Load fields are snapshotted on the accepting edge so later input changes
  // cannot leak into the LOAD cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ld_hour <= '0;
      r_ld_min  <= '0;
      r_ld_sec  <= '0;
    end else if (w_accept) begin
      r_ld_hour <= set_hour;
      r_ld_min  <= set_min;
      r_ld_sec  <= set_sec;
    end
  end

  // --------------------------------------------------------------------------
  // Next time-of-day after one second
  // --------------------------------------------------------------------------
  assign w_tick_due  = (r_state == RUN) && en && (r_presc == PRE_LAST);
  assign w_sec_wrap  = (r_sec == SEC_MAX);
  assign w_min_wrap  = (r_min == MIN_MAX);
  assign w_hour_wrap = (r_hour24 == HOUR_MAX);

  always_comb begin
    w_sec_nxt  = w_sec_wrap ? 6'd0 : r_sec + 6'd1;
    w_min_nxt  = r_min;
    w_hour_nxt = r_hour24;
    if (w_sec_wrap) begin
      w_min_nxt = w_min_wrap ? 6'd0 : r_min + 6'd1;
      if (w_min_wrap) begin
        w_hour_nxt = w_hour_wrap ? 5'd0 : r_hour24 + 5'd1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Prescaler, time counters and status pulses
  // --------------------------------------------------------------------------
  // The LOAD cycle always wins over a tick falling due in it: the prescaler
  // restarts from zero whether the load is accepted or rejected.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc    <= '0;
      r_sec      <= '0;
      r_min      <= '0;
      r_hour24   <= '0;
      r_tick     <= 1'b0;
      r_day_wrap <= 1'b0;
      r_set_err  <= 1'b0;
    end else begin
      r_tick     <= 1'b0;
      r_day_wrap <= 1'b0;
      r_set_err  <= 1'b0;
      if (r_state == LOAD) begin
        r_presc <= '0;
        if (fields_ok(r_ld_hour, r_ld_min, r_ld_sec)) begin
          r_hour24 <= r_ld_hour;
          r_min    <= r_ld_min;
          r_sec    <= r_ld_sec;
        end else begin
          r_set_err <= 1'b1;
        end
      end else if (en) begin
        if (w_tick_due) begin
          r_presc    <= '0;
          r_sec      <= w_sec_nxt;
          r_min      <= w_min_nxt;
          r_hour24   <= w_hour_nxt;
          r_tick     <= 1'b1;
          r_day_wrap <= w_sec_wrap && w_min_wrap && w_hour_wrap;
        end else begin
          r_presc <= r_presc + PW'(1);
        end
      end
    end
  end

  assign sec      = r_sec;
  assign min      = r_min;
  assign tick     = r_tick;
  assign day_wrap = r_day_wrap;
  assign set_err  = r_set_err;

  // --------------------------------------------------------------------------
  // Alarm: compared against the time a tick is about to produce, so a load
  // landing on the alarm time never fires it.
  // --------------------------------------------------------------------------
`ifdef RTC_ALARM_EN
  logic r_alarm;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_alarm <= 1'b0;
    end else begin
      r_alarm <= w_tick_due && alarm_arm &&
                 (w_hour_nxt == alarm_hour) &&
                 (w_min_nxt == alarm_min) &&
                 (w_sec_nxt == 6'd0);
    end
  end

  assign alarm = r_alarm;
`else
  logic w_unused_alarm;
  assign w_unused_alarm = ^{alarm_hour, alarm_min, alarm_arm};
  assign alarm          = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Display format decode
  // --------------------------------------------------------------------------
  hour_fmt u_hour_fmt (
    .hour24 (r_hour24),
    .mode12 (mode12),
    .hour   (hour),
    .nAM_PM (nAM_PM)
  );

endmodule
`default_nettype wire

// File: tb/tb_rtc_counter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rtc_counter
//  Purpose  : Directed self-checking bench for rtc_counter at CLK_HZ = 4.
//             Inputs change and outputs are sampled 1 ns after each rising
//             edge. Alarm scenarios expect a pulse only when RTC_ALARM_EN is
//             defined; otherwise alarm must stay low.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rtc_counter;

  localparam int CLK_HZ = 4;

  logic       clk;
  logic       rst;
  logic       en;
  logic       mode12;
  logic       set_valid;
  logic       set_ready;
  logic [4:0] set_hour;
  logic [5:0] set_min;
  logic [5:0] set_sec;
  logic       set_err;
  logic [4:0] hour;
  logic [5:0] min;
  logic [5:0] sec;
  logic       nAM_PM;
  logic       tick;
  logic       day_wrap;
  logic [4:0] alarm_hour;
  logic [5:0] alarm_min;
  logic       alarm_arm;
  logic       alarm;

  int checks   = 0;
  int failures = 0;

  rtc_counter #(.CLK_HZ(CLK_HZ)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .mode12     (mode12),
    .set_valid  (set_valid),
    .set_ready  (set_ready),
    .set_hour   (set_hour),
    .set_min    (set_min),
    .set_sec    (set_sec),
    .set_err    (set_err),
    .hour       (hour),
    .min        (min),
    .sec        (sec),
    .nAM_PM     (nAM_PM),
    .tick       (tick),
    .day_wrap   (day_wrap),
    .alarm_hour (alarm_hour),
    .alarm_min  (alarm_min),
    .alarm_arm  (alarm_arm),
    .alarm      (alarm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Accepting edge, then LOAD edge; inputs are scrambled after acceptance.
  task automatic do_load(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
    set_valid = 1'b1;
    set_hour  = h;
    set_min   = m;
    set_sec   = s;
    step(1);
    check("ready_low_in_load", {31'd0, set_ready}, 32'd0);
    set_valid = 1'b0;
    set_hour  = 5'd31;
    set_min   = 6'd63;
    set_sec   = 6'd63;
    step(1);
    check("ready_after_load", {31'd0, set_ready}, 32'd1);
  endtask

  task automatic check_time(input string tag, input logic [4:0] h,
                            input logic [5:0] m, input logic [5:0] s);
    check({tag, "_hour"}, {27'd0, hour}, {27'd0, h});
    check({tag, "_min"},  {26'd0, min},  {26'd0, m});
    check({tag, "_sec"},  {26'd0, sec},  {26'd0, s});
  endtask

  initial begin
    rst        = 1'b1;
    en         = 1'b1;
    mode12     = 1'b0;
    set_valid  = 1'b0;
    set_hour   = '0;
    set_min    = '0;
    set_sec    = '0;
    alarm_hour = 5'd7;
    alarm_min  = 6'd30;
    alarm_arm  = 1'b0;

    // Reset state
    step(3);
    check("rst_ready", {31'd0, set_ready}, 32'd0);
    check("rst_tick", {31'd0, tick}, 32'd0);
    check("rst_alarm", {31'd0, alarm}, 32'd0);
    check_time("rst", 5'd0, 6'd0, 6'd0);

    // Release: ready after one edge, tick every 4th cycle
    rst = 1'b0;
    step(1);
    check("ready_rise", {31'd0, set_ready}, 32'd1);
    check("no_tick_e1", {31'd0, tick}, 32'd0);
    step(2);
    check("no_tick_e3", {31'd0, tick}, 32'd0);
    step(1);
    check("tick_e4", {31'd0, tick}, 32'd1);
    check("sec_e4", {26'd0, sec}, 32'd1);
    step(1);
    check("tick_pulse_end", {31'd0, tick}, 32'd0);
    step(3);
    check("tick_e8", {31'd0, tick}, 32'd1);
    check("sec_e8", {26'd0, sec}, 32'd2);

    // Midnight rollover
    do_load(5'd23, 6'd59, 6'd58);
    check_time("ld_235958", 5'd23, 6'd59, 6'd58);
    check("pm_2359", {31'd0, nAM_PM}, 32'd1);
    step(4);
    check_time("t_235959", 5'd23, 6'd59, 6'd59);
    check("dw_not_yet", {31'd0, day_wrap}, 32'd0);
    step(4);
    check_time("t_000000", 5'd0, 6'd0, 6'd0);
    check("tick_midnight", {31'd0, tick}, 32'd1);
    check("dw_midnight", {31'd0, day_wrap}, 32'd1);
    check("am_midnight", {31'd0, nAM_PM}, 32'd0);
    step(1);
    check("dw_pulse_end", {31'd0, day_wrap}, 32'd0);

    // 12/24-hour decode
    mode12 = 1'b1;
    do_load(5'd13, 6'd5, 6'd0);
    check("h12_13", {27'd0, hour}, 32'd1);
    check("pm_13", {31'd0, nAM_PM}, 32'd1);
    mode12 = 1'b0;
    #1;
    check_time("h24_13", 5'd13, 6'd5, 6'd0);

    // Out-of-range load: rejected, prescaler restarts
    do_load(5'd24, 6'd0, 6'd0);
    check("err_pulse", {31'd0, set_err}, 32'd1);
    check_time("err_keep", 5'd13, 6'd5, 6'd0);
    step(1);
    check("err_end", {31'd0, set_err}, 32'd0);
    step(2);
    check("err_no_early_tick", {31'd0, tick}, 32'd0);
    step(1);
    check("err_tick", {31'd0, tick}, 32'd1);
    check("err_sec", {26'd0, sec}, 32'd1);

    // Midnight in 12-hour mode
    mode12 = 1'b1;
    do_load(5'd0, 6'd0, 6'd0);
    check("h12_0", {27'd0, hour}, 32'd12);
    check("am_0", {31'd0, nAM_PM}, 32'd0);
    check("no_err_valid", {31'd0, set_err}, 32'd0);
    mode12 = 1'b0;

    // Pause mid-second: prescaler at 2 when en drops
    step(2);
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      check("pause_no_tick", {31'd0, tick}, 32'd0);
    end
    check("pause_sec", {26'd0, sec}, 32'd0);
    en = 1'b1;
    step(1);
    check("resume_no_tick", {31'd0, tick}, 32'd0);
    step(1);
    check("resume_tick", {31'd0, tick}, 32'd1);
    check("resume_sec", {26'd0, sec}, 32'd1);

    // Alarm, armed
    alarm_arm = 1'b1;
    do_load(5'd7, 6'd29, 6'd59);
    check("alarm_idle", {31'd0, alarm}, 32'd0);
    step(4);
    check_time("t_073000", 5'd7, 6'd30, 6'd0);
`ifdef RTC_ALARM_EN
    check("alarm_fire", {31'd0, alarm}, 32'd1);
`else
    check("alarm_tied", {31'd0, alarm}, 32'd0);
`endif
    step(1);
    check("alarm_end", {31'd0, alarm}, 32'd0);

    // Load landing on the alarm time must not fire
    do_load(5'd7, 6'd30, 6'd0);
    check("alarm_on_load", {31'd0, alarm}, 32'd0);
    step(1);
    check("alarm_after_load", {31'd0, alarm}, 32'd0);

    // Alarm disarmed
    alarm_arm = 1'b0;
    do_load(5'd7, 6'd29, 6'd59);
    step(4);
    check("alarm_disarmed_tick", {31'd0, tick}, 32'd1);
    check("alarm_disarmed", {31'd0, alarm}, 32'd0);

    // Reset during LOAD abandons the load
    set_valid = 1'b1;
    set_hour  = 5'd10;
    set_min   = 6'd10;
    set_sec   = 6'd10;
    step(1);
    set_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("rst_async_ready", {31'd0, set_ready}, 32'd0);
    step(1);
    check_time("rst_in_load", 5'd0, 6'd0, 6'd0);
    rst = 1'b0;
    step(2);
    check_time("post_rst", 5'd0, 6'd0, 6'd0);
    check("post_rst_ready", {31'd0, set_ready}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
